bus_mem: RTL and testbench

Synthesisable, parametrised big-endian memory slave for the CPU/MMU data bus, with configurable wait states, alignment/range fault reporting and memory-mapped halt and console registers. It succeeds the always-ready behavioural memory model. It sits directly on the `db_*` bus behind `CPU_MMU`, and it serves both simulation benches and FPGA builds.

---
 rtl/bus_mem_pkg.sv | 34 +++
 rtl/bus_mem_con_fifo.sv | 52 +++++
 rtl/bus_mem.sv | 155 +++++++++++++++
 tb/tb_bus_mem.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// rtl/bus_mem_pkg.sv - data bus encodings, default MMIO addresses and FSM states for bus_mem
package bus_mem_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_NONE = 2'd0,
    MEM_ACCESS_R    = 2'd1,
    MEM_ACCESS_W    = 2'd2,
    MEM_ACCESS_X    = 2'd3
  } mem_access_t;

  typedef enum logic [1:0] {
    MEM_LEN_B = 2'd0,
    MEM_LEN_H = 2'd1,
    MEM_LEN_W = 2'd2
  } mem_len_t;

  localparam logic [31:0] BUS_MMIO_HLT = 32'ha0000000;
  localparam logic [31:0] BUS_MMIO_CON = 32'ha0000001;

  typedef enum logic [1:0] {
    BUS_MEM_ST_IDLE = 2'd0,
    BUS_MEM_ST_WAIT = 2'd1,
    BUS_MEM_ST_ACK  = 2'd2
  } bus_mem_st_t;

  function automatic logic is_misaligned(input mem_len_t len, input logic [1:0] lsb);
    case (len)
      MEM_LEN_B: is_misaligned = 1'b0;
      MEM_LEN_H: is_misaligned = lsb[0];
      default:   is_misaligned = (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/bus_mem_con_fifo.sv
// rtl/bus_mem_con_fifo.sv - synchronous console FIFO; pushes are refused while full
module bus_mem_con_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_buf[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr] <= i_push_data;
  end

endmodule

// File: rtl/bus_mem.sv
// rtl/bus_mem.sv - big-endian data bus memory slave with wait states, faults, halt and console MMIO
// Console FIFO present only when BUS_MEM_CONSOLE_EN is defined.
module bus_mem
  import bus_mem_pkg::*;
#(
  parameter int          MEM_SIZE  = 4096,
  parameter int          LATENCY   = 0,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] HLT_ADDR  = BUS_MMIO_HLT,
  parameter logic [31:0] CON_ADDR  = BUS_MMIO_CON,
  parameter int          CON_DEPTH = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] db_addr,
  input  logic [31:0] db_dataOut,
  input  mem_access_t db_accessType,
  input  mem_len_t    db_memLen,
  output logic [31:0] db_dataIn,
  output logic        db_ready,
  output logic        db_fault,
  output logic        hlt,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);
  localparam int          AW  = $clog2(MEM_SIZE);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  bus_mem_st_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_fault;
  logic [7:0]  r_mem [MEM_SIZE];

  logic        w_is_read, w_is_write, w_hit_hlt, w_hit_con;
  logic        w_range_err, w_align_err, w_fault, w_exec, w_con_stall;
  mem_len_t    w_len;
  logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [31:0] w_ram_rdata, w_rdata, w_con_free;

  assign w_is_read   = (db_accessType == MEM_ACCESS_R) || (db_accessType == MEM_ACCESS_X);
  assign w_is_write  = (db_accessType == MEM_ACCESS_W);
  assign w_len       = (db_accessType == MEM_ACCESS_X) ? MEM_LEN_W : db_memLen;
  assign w_hit_hlt   = (db_addr == HLT_ADDR);
  assign w_hit_con   = (db_addr == CON_ADDR);
  // MMIO decode wins over range, range wins over alignment
  assign w_range_err = !w_hit_hlt && !w_hit_con && (db_addr >= 32'(MEM_SIZE));
  assign w_align_err = !w_hit_hlt && !w_hit_con && !w_range_err && is_misaligned(w_len, db_addr[1:0]);
  assign w_fault     = w_range_err || w_align_err;
  assign w_exec      = (r_state == BUS_MEM_ST_WAIT) && (r_cnt == 4'd0) && !w_con_stall;

  assign w_a0 = db_addr[AW-1:0];
  assign w_a1 = w_a0 + 1'b1;
  assign w_a2 = w_a0 + 2'd2;
  assign w_a3 = w_a0 + 2'd3;

  always_comb begin
    w_ram_rdata = '0;
    case (w_len)
      MEM_LEN_B: w_ram_rdata = {24'b0, r_mem[w_a0]};
      MEM_LEN_H: w_ram_rdata = {16'b0, r_mem[w_a0], r_mem[w_a1]};
      default:   w_ram_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    endcase
  end

  assign w_rdata = w_hit_hlt ? {31'b0, hlt} :
                   w_hit_con ? w_con_free :
                   w_fault   ? 32'b0 : w_ram_rdata;

`ifdef BUS_MEM_CONSOLE_EN
  logic [$clog2(CON_DEPTH):0] w_con_count;
  logic                       w_con_full, w_con_empty, w_con_push;
  logic [7:0]                 w_con_head;

  assign w_con_push  = w_exec && w_is_write && w_hit_con;
  assign w_con_stall = w_is_write && w_hit_con && w_con_full;
  assign w_con_free  = 32'(CON_DEPTH) - 32'(w_con_count);
  assign con_data    = w_con_head;
  assign con_valid   = !w_con_empty;

  bus_mem_con_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
    .clk         (clk),
    .rst_n       (res),
    .i_push      (w_con_push),
    .i_push_data (db_dataOut[7:0]),
    .i_pop       (con_ready),
    .o_head      (w_con_head),
    .o_full      (w_con_full),
    .o_empty     (w_con_empty),
    .o_count     (w_con_count)
  );
`else
  logic w_unused_con_ready;
  assign w_unused_con_ready = con_ready;
  assign w_con_stall = 1'b0;
  assign w_con_free  = 32'b0;
  assign con_data    = 8'b0;
  assign con_valid   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      BUS_MEM_ST_IDLE: if (db_accessType != MEM_ACCESS_NONE) begin
        w_state_nxt = BUS_MEM_ST_WAIT;
        w_cnt_nxt   = LAT;
      end
      BUS_MEM_ST_WAIT: begin
        if (r_cnt != 4'd0)     w_cnt_nxt   = r_cnt - 1'b1;
        else if (!w_con_stall) w_state_nxt = BUS_MEM_ST_ACK;
      end
      default: w_state_nxt = BUS_MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= BUS_MEM_ST_IDLE;
      r_cnt     <= 4'd0;
      r_fault   <= 1'b0;
      db_dataIn <= 32'b0;
      hlt       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_exec && w_fault;
      if (w_exec && w_is_read) db_dataIn <= w_rdata;
      if (w_exec && w_is_write && w_hit_hlt) hlt <= 1'b1;
    end
  end

  // RAM has no reset so its contents survive a bus reset
  always_ff @(posedge clk) begin
    if (w_exec && w_is_write && !w_hit_hlt && !w_hit_con && !w_fault) begin
      case (w_len)
        MEM_LEN_B: r_mem[w_a0] <= db_dataOut[7:0];
        MEM_LEN_H: begin
          r_mem[w_a0] <= db_dataOut[15:8];
          r_mem[w_a1] <= db_dataOut[7:0];
        end
        default: begin
          r_mem[w_a0] <= db_dataOut[31:24];
          r_mem[w_a1] <= db_dataOut[23:16];
          r_mem[w_a2] <= db_dataOut[15:8];
          r_mem[w_a3] <= db_dataOut[7:0];
        end
      endcase
    end
  end

  assign db_ready = (r_state == BUS_MEM_ST_ACK);
  assign db_fault = r_fault;

endmodule

// File: tb/tb_bus_mem.sv
// tb/tb_bus_mem.sv - randomized self-checking bench for bus_mem against a byte-array reference model
`timescale 1ns/1ps
module tb_bus_mem;
  import bus_mem_pkg::*;

  localparam int          LAT   = 3;
  localparam int          MSZ   = 4096;
  localparam int          DEPTH = 2;
  localparam logic [31:0] HLT   = 32'ha0000000;
  localparam logic [31:0] CON   = 32'ha0000001;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [31:0] db_addr = '0;
  logic [31:0] db_dataOut = '0;
  mem_access_t db_accessType = MEM_ACCESS_NONE;
  mem_len_t    db_memLen = MEM_LEN_W;
  logic [31:0] db_dataIn;
  logic        db_ready, db_fault, hlt;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;

  always #5 clk = ~clk;

  bus_mem #(
    .MEM_SIZE(MSZ), .LATENCY(LAT), .INIT_FILE(""),
    .HLT_ADDR(HLT), .CON_ADDR(CON), .CON_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .res(res), .db_addr(db_addr), .db_dataOut(db_dataOut),
    .db_accessType(db_accessType), .db_memLen(db_memLen), .db_dataIn(db_dataIn),
    .db_ready(db_ready), .db_fault(db_fault), .hlt(hlt),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready)
  );

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mm [0:MSZ-1];
  logic        m_hlt = 1'b0;
  logic [31:0] m_din = '0;
  logic [7:0]  m_con [$];
  logic [7:0]  popped [$];

  always @(negedge clk) if (con_valid && con_ready) popped.push_back(con_data);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_access(input logic [1:0] t, input logic [1:0] l,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic exp_fault);
    bit rd, wr;
    int n;
    logic [31:0] v;
    rd = (t == 2'd1) || (t == 2'd3);
    wr = (t == 2'd2);
    n  = (t == 2'd3) ? 4 : (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
    v  = '0;
    exp_fault = 1'b0;
    if (a == HLT) begin
      if (wr) m_hlt = 1'b1;
      v = {31'b0, m_hlt};
    end else if (a == CON) begin
`ifdef BUS_MEM_CONSOLE_EN
      if (wr) m_con.push_back(d[7:0]);
      v = DEPTH - m_con.size();
`endif
    end else if (a >= MSZ || (a % n) != 0) begin
      exp_fault = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < n; i++) mm[a+i] = d[8*(n-1-i) +: 8];
    end else begin
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[a+i]);
    end
    if (rd) m_din = v;
  endtask

  task automatic access(input logic [1:0] t, input logic [1:0] l,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    int   n;
    bit   got;
    logic f_obs, exp_f;
    n = 0;
    got = 0;
    @(posedge clk); #1;
    db_accessType = mem_access_t'(t);
    db_memLen     = mem_len_t'(l);
    db_addr       = a;
    db_dataOut    = d;
    while (!got && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk); got = db_ready;
    end
    f_obs = db_fault;
    model_access(t, l, a, d, exp_f);
    check({tag, ":lat"}, n, LAT + 2);
    check({tag, ":fault"}, f_obs, exp_f);
    check({tag, ":din"}, db_dataIn, m_din);
    @(posedge clk); #1;
    db_accessType = MEM_ACCESS_NONE;
    @(negedge clk);
    check({tag, ":onewide"}, db_ready, 1'b0);
  endtask

  initial begin
    int          n;
    bit          got;
    logic        f;
    logic [1:0]  t, l;
    logic [31:0] a;
    int          r;

    repeat (3) @(negedge clk);
    check("rst:ready", db_ready, 1'b0);
    check("rst:fault", db_fault, 1'b0);
    check("rst:din", db_dataIn, 32'h0);
    check("rst:hlt", hlt, 1'b0);
    check("rst:con_valid", con_valid, 1'b0);
    check("rst:con_data", con_data, 8'h0);
    @(posedge clk); #1 res = 1'b1;

    for (int i = 0; i < 64; i += 4) access(2'd2, 2'd2, 32'(i), $urandom, "init_lo");
    access(2'd2, 2'd2, MSZ - 8, $urandom, "init_hi0");
    access(2'd2, 2'd2, MSZ - 4, $urandom, "init_hi1");

    access(2'd2, 2'd2, 32'h10, 32'h11223344, "w10");
    access(2'd1, 2'd0, 32'h12, 32'h0, "rb12");
    check("rb12:lit", db_dataIn, 32'h33);
    access(2'd1, 2'd1, 32'h10, 32'h0, "rh10");
    check("rh10:lit", db_dataIn, 32'h1122);

    access(2'd1, 2'd2, 32'h2, 32'h0, "rw2_align");
    access(2'd2, 2'd1, 32'h5, 32'hbeef, "wh5_align");
    access(2'd1, 2'd2, 32'h4, 32'h0, "rw4_unchanged");
    access(2'd1, 2'd2, 32'h1000, 32'h0, "r1000_range");
    check("r1000:lit", db_dataIn, 32'h0);
    access(2'd3, 2'd0, 32'h8, 32'h0, "x8_word");

    for (int i = 0; i < 120; i++) begin
      t = 2'($urandom_range(1, 3));
      l = 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 63));
      else if (r < 8) a = 32'(MSZ - 8 + $urandom_range(0, 7));
      else            a = $urandom_range(MSZ, 32'h9fffffff);
      access(t, l, a, $urandom, "rand");
    end

    access(2'd2, 2'd2, HLT, 32'h0, "hlt_w");
    check("hlt:set", hlt, m_hlt);
    access(2'd1, 2'd2, HLT, 32'h0, "hlt_r");
    check("hlt_r:lit", db_dataIn, 32'h1);

`ifdef BUS_MEM_CONSOLE_EN
    access(2'd2, 2'd2, CON, 32'h41, "conA");
    access(2'd2, 2'd1, CON, 32'h42, "conB");
    check("con:valid", con_valid, 1'b1);
    check("con:head", con_data, 8'h41);
    access(2'd1, 2'd2, CON, 32'h0, "con_free_full");
    @(posedge clk); #1;
    db_accessType = MEM_ACCESS_W; db_memLen = MEM_LEN_B; db_addr = CON; db_dataOut = 32'h43;
    got = 0;
    repeat (20) begin @(negedge clk); if (db_ready) got = 1; end
    check("con:stall", got, 1'b0);
    @(posedge clk); #1 con_ready = 1'b1;
    n = 0; got = 0;
    while (!got && n < 40) begin @(posedge clk); n++; @(negedge clk); got = db_ready; end
    check("con:unstall_lat", n, 2);
    model_access(2'd2, 2'd0, CON, 32'h43, f);
    @(posedge clk); #1 db_accessType = MEM_ACCESS_NONE;
    repeat (6) @(posedge clk);
    #1 con_ready = 1'b0;
    check("con:popcount", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++) check("con:order", popped[i], m_con[i]);
    m_con.delete();
    check("con:drained", con_valid, 1'b0);
    access(2'd1, 2'd2, CON, 32'h0, "con_free_empty");
`else
    access(2'd2, 2'd2, CON, 32'h41, "con_w_off");
    check("con_off:valid", con_valid, 1'b0);
    check("con_off:data", con_data, 8'h0);
    access(2'd1, 2'd2, CON, 32'h0, "con_r_off");
    check("con_off:lit", db_dataIn, 32'h0);
`endif

    @(posedge clk); #1;
    db_accessType = MEM_ACCESS_W; db_memLen = MEM_LEN_W; db_addr = 32'h20; db_dataOut = 32'hdeadbeef;
    @(posedge clk); @(posedge clk); #1;
    res = 1'b0;
    db_accessType = MEM_ACCESS_NONE;
    got = 0;
    repeat (4) begin @(negedge clk); if (db_ready) got = 1; end
    check("midrst:noack", got, 1'b0);
    check("midrst:hlt", hlt, 1'b0);
    check("midrst:din", db_dataIn, 32'h0);
    check("midrst:fault", db_fault, 1'b0);
    m_hlt = 1'b0;
    m_din = '0;
    @(posedge clk); #1 res = 1'b1;
    access(2'd1, 2'd2, 32'h20, 32'h0, "midrst_r20");
    access(2'd1, 2'd2, 32'h10, 32'h0, "postrst_r10");
    access(2'd1, 2'd2, HLT, 32'h0, "postrst_hlt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
